// File: rtl/ex_mem_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_pkg
// Shared definitions for the EX/MEM pipeline register slice.
//   - default widths for the data path and the register write index
//   - state encoding for the two-entry elastic buffer
//   - helper to size the packed payload carried through the buffer
// No ports: imported by pipe_skid_buf, ex_mem_stage_if and ex_mem_stage.
// ---------------------------------------------------------------------------
package ex_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IDX_W  = 4;

  // RegWrite, MemtoReg, MemWrite, MemRead
  localparam int CTRL_W = 4;

  // EMPTY: nothing held, ONE: main valid, FULL: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Width of the packed control + result + store data + index payload
  function automatic int payload_width(input int data_w, input int idx_w);
    return CTRL_W + 2 * data_w + idx_w;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_if
// Valid/ready payload bus used on both sides of the EX/MEM stage.
//   valid           producer -> consumer, payload below is meaningful
//   ready           consumer -> producer, consumer accepts this cycle
//   reg_write       register file write enable
//   mem_to_reg      write-back selects memory data
//   mem_write       store enable
//   mem_read        load enable
//   result          ALU result / memory address   (DATA_W)
//   data_in         store data                    (DATA_W)
//   reg_write_index destination register          (IDX_W)
// Modports: master drives the payload, slave drives ready.
// ---------------------------------------------------------------------------
interface ex_mem_stage_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
);

  logic              valid;
  logic              ready;
  logic              reg_write;
  logic              mem_to_reg;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  reg_write_index;

  modport master (
    output valid,
    output reg_write,
    output mem_to_reg,
    output mem_write,
    output mem_read,
    output result,
    output data_in,
    output reg_write_index,
    input  ready
  );

  modport slave (
    input  valid,
    input  reg_write,
    input  mem_to_reg,
    input  mem_write,
    input  mem_read,
    input  result,
    input  data_in,
    input  reg_write_index,
    output ready
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic two-entry elastic buffer (main + skid register) with a registered
// ready so the upstream ready never depends combinationally on the
// downstream ready. Full throughput of one payload per cycle while the
// consumer keeps accepting.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop everything held and any payload offered now
//   in_valid / in_ready upstream handshake, in_data payload (WIDTH)
//   out_valid/out_ready downstream handshake, out_data payload (WIDTH),
//                       out_data always comes straight from the main register
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_t       state;
  buf_state_t       next_state;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Handshakes. The out side is derived from the state directly rather than
  // from out_valid to keep the output process free of feedback.
  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = (state != EMPTY) & out_ready;

  assign in_ready = ready_q;
  assign out_data = main_q;

  // State register. Ready is recomputed from the next state so it is a flop
  // output; it stays low during reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != FULL);
    end
  end

  // Next-state logic. Flush overrides every transfer in the same cycle.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) next_state = ONE;
        end
        ONE: begin
          if (in_xfer && !out_xfer)      next_state = FULL;
          else if (!in_xfer && out_xfer) next_state = EMPTY;
        end
        FULL: begin
          if (out_xfer) next_state = ONE;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Output logic: downstream valid and the register load strobes.
  // In FULL ready_q is low, so no in-transfer can coincide with a skid move.
  always_comb begin
    out_valid      = 1'b0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        load_main_in = in_xfer;
      end
      ONE: begin
        out_valid    = 1'b1;
        load_main_in = in_xfer & out_xfer;
        load_skid    = in_xfer & ~out_xfer;
      end
      FULL: begin
        out_valid      = 1'b1;
        load_main_skid = out_xfer;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
    if (flush) begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Payload storage. Registers keep their contents when not loaded so the
  // outputs stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register built on a two-entry elastic buffer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        kill everything held in the stage (branch / exception)
//   ex_side      slave side of the EX payload bus (valid1/ready1 + fields)
//   mem_side     master side of the MEM payload bus (valid2/ready2 + fields)
//   fwd_valid    EX-forwarding tap: main holds a register-writing non-load
//   fwd_index    destination register of the main entry
//   fwd_data     ALU result of the main entry
// Side-effect controls toward MEM are forced to 0 whenever the stage is
// empty; data fields show whatever main holds (zero after reset).
// ---------------------------------------------------------------------------
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_mem_stage_if.slave     ex_side,
  ex_mem_stage_if.master    mem_side,
  output logic              fwd_valid,
  output logic [IDX_W-1:0]  fwd_index,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PAY_W = payload_width(DATA_W, IDX_W);

  logic [PAY_W-1:0]  in_payload;
  logic [PAY_W-1:0]  out_payload;
  logic              out_valid;

  logic              raw_reg_write;
  logic              raw_mem_to_reg;
  logic              raw_mem_write;
  logic              raw_mem_read;
  logic [DATA_W-1:0] raw_result;
  logic [DATA_W-1:0] raw_data_in;
  logic [IDX_W-1:0]  raw_index;

  // Field order is fixed here and in the unpack below; nothing else cares.
  assign in_payload = {ex_side.reg_write,
                       ex_side.mem_to_reg,
                       ex_side.mem_write,
                       ex_side.mem_read,
                       ex_side.result,
                       ex_side.data_in,
                       ex_side.reg_write_index};

  pipe_skid_buf #(
    .WIDTH (PAY_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_side.valid),
    .in_ready  (ex_side.ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (mem_side.ready),
    .out_data  (out_payload)
  );

  assign {raw_reg_write,
          raw_mem_to_reg,
          raw_mem_write,
          raw_mem_read,
          raw_result,
          raw_data_in,
          raw_index} = out_payload;

  // Controls that cause architectural side effects are gated by valid so a
  // stale main entry can never write the register file or memory.
  assign mem_side.valid           = out_valid;
  assign mem_side.reg_write       = raw_reg_write & out_valid;
  assign mem_side.mem_to_reg      = raw_mem_to_reg;
  assign mem_side.mem_write       = raw_mem_write & out_valid;
  assign mem_side.mem_read        = raw_mem_read & out_valid;
  assign mem_side.result          = raw_result;
  assign mem_side.data_in         = raw_data_in;
  assign mem_side.reg_write_index = raw_index;

  // Loads are excluded: their value is not known until MEM returns it.
  assign fwd_valid = out_valid & raw_reg_write & ~raw_mem_read;
  assign fwd_index = raw_index;
  assign fwd_data  = raw_result;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of the Result and DataIn paths.
REQ-002 Parameter IDX_W, default 4, SHALL set the width of the register write index.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Valid1  input  1  SHALL mark the EX-side payload as valid.
REQ-006 Ready1  output  1  SHALL indicate the stage can accept a payload this cycle.
REQ-007 Flush  input  1  SHALL discard all held entries (branch or exception kill).
REQ-008 RegWrite1, MemtoReg1, MemWrite1, MemRead1  input  1 each  SHALL be the EX-side control bits.
REQ-009 Result1, DataIn1  input  DATA_W each  SHALL be the ALU result and the store data.
REQ-010 RegWriteIndex1  input  IDX_W  SHALL be the destination register index.
REQ-011 Valid2  output  1  SHALL mark the MEM-side payload as valid.
REQ-012 Ready2  input  1  SHALL indicate that MEM consumes the payload this cycle.
REQ-013 RegWrite2, MemtoReg2, MemWrite2, MemRead2, Result2, DataIn2, RegWriteIndex2  output  SHALL have the widths of their "1" counterparts.
REQ-014 FwdValid  output  1, FwdIndex  output  IDX_W, FwdData  output  DATA_W  SHALL form the EX-forwarding tap.

Function
REQ-015 Transfer in SHALL occur when Valid1 and Ready1 are both high; transfer out SHALL occur when Valid2 and Ready2 are both high.
REQ-016 The stage SHALL be a 2-entry elastic buffer with a main register driving the "2" outputs and a skid register.
REQ-017 State machine states SHALL be EMPTY, ONE and FULL.
REQ-018 EMPTY, with an in-transfer, SHALL load main and go to ONE; otherwise it SHALL stay EMPTY.
REQ-019 ONE, with an in-transfer and no out-transfer, SHALL load skid and go to FULL.
REQ-020 ONE, with an out-transfer and no in-transfer, SHALL go to EMPTY.
REQ-021 ONE, with both an in-transfer and an out-transfer, SHALL reload main and stay in ONE.
REQ-022 ONE, with neither transfer, SHALL hold.
REQ-023 FULL, with an out-transfer, SHALL move skid to main and go to ONE; otherwise it SHALL hold.
REQ-024 Ready1 SHALL be a registered signal, high exactly when the state is not FULL; there SHALL be no combinational path from Ready2 to Ready1.
REQ-025 Valid2 SHALL be high exactly in ONE or FULL.
REQ-026 Latency from an in-transfer to Valid2 SHALL be 1 cycle when the stage is EMPTY.
REQ-027 Sustained throughput SHALL be 1 payload per cycle while Ready2 stays high.
REQ-028 All "2" outputs SHALL hold stable while Valid2 is high and Ready2 is low.
REQ-029 Flush SHALL force EMPTY on the next edge and take priority over any simultaneous in-transfer or out-transfer.
REQ-030 A payload presented in the Flush cycle SHALL be dropped.
REQ-031 When Valid2 is low, RegWrite2, MemWrite2 and MemRead2 SHALL read 0 so that no side effect leaks.
REQ-032 When Valid2 is low, the data outputs SHALL be don't-care but deterministic.
REQ-033 FwdValid SHALL equal Valid2 AND RegWrite2 AND NOT MemRead2.
REQ-034 FwdIndex SHALL equal RegWriteIndex2 and FwdData SHALL equal Result2; all forwarding outputs SHALL be combinational from main.
REQ-035 Payload SHALL pass through unmodified with no width conversion.

Reset
REQ-036 Asserting Rst_n low SHALL immediately force the state to EMPTY, Ready1 to 0, Valid2 to 0, and all main and skid fields to 0.
REQ-037 Ready1 SHALL rise on the first Clk edge after Rst_n deasserts.
REQ-038 A reset asserted mid-operation SHALL discard both entries without any out-transfer.

Structure
REQ-039 Package ex_mem_pkg SHALL hold the state encoding typedef (EMPTY, ONE, FULL) and the default DATA_W and IDX_W constants.
REQ-040 A single sub-module pipe_skid_buf, generic in payload width, SHALL implement the storage and the FSM.
REQ-041 ex_mem_stage SHALL pack and unpack the fields and generate the forwarding tap.

Verification
REQ-042 Reset release, then Valid1=1 with Result1=0x1234, RegWriteIndex1=3, RegWrite1=1 and Ready2=1 -> next cycle Valid2=1, Result2=0x1234, FwdValid=1, FwdIndex=3.
REQ-043 Ready2=0 with 3 back-to-back payloads A, B, C -> A and B accepted, Ready1=0 after B, C held at input; on Ready2=1, outputs A, B, C in order with no loss or duplication.
REQ-044 FULL state plus Flush=1 and Valid1=1 in the same cycle -> next cycle Valid2=0, Ready1=1, MemWrite2=0; the Flush-cycle payload never appears.
REQ-045 Valid1=1 with MemRead1=1, RegWrite1=1 -> Valid2=1 and FwdValid=0.
REQ-046 Rst_n pulsed low mid-cycle while FULL -> Valid2 and Ready1 drop asynchronously; after release, the first new payload emerges with latency 1.
REQ-047 Random Valid1/Ready2 with 1000 payloads -> scoreboard shows in-order delivery and Ready1 never depends combinationally on Ready2.
